// File: rtl/udp_echo_responder.sv
// UDP echo responder: buffers frames addressed to LISTEN_PORT and sends them back
// to the sender; frames for other ports, errored frames and oversize frames are drained.
//
// state      | meaning
// IDLE       | waiting for an rx header
// RX_STORE   | writing payload to RAM for echo
// RX_DROP    | draining a frame not addressed to us
// TX_HDR     | presenting the reply header
// TX_PAYLOAD | streaming the buffered payload back out
module udp_echo_responder #(
  parameter logic [15:0] LISTEN_PORT = 16'd5000,
  parameter int          MAX_PAYLOAD = 1472,
  parameter int          ADDR_WIDTH  = 11,
  parameter logic [7:0]  REPLY_TTL   = 8'd64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_udp_hdr_valid,
  output logic        s_udp_hdr_ready,
  input  logic [31:0] s_udp_ip_source_ip,
  input  logic [15:0] s_udp_source_port,
  input  logic [15:0] s_udp_dest_port,
  input  logic [7:0]  s_udp_payload_axis_tdata,
  input  logic        s_udp_payload_axis_tvalid,
  output logic        s_udp_payload_axis_tready,
  input  logic        s_udp_payload_axis_tlast,
  input  logic        s_udp_payload_axis_tuser,
  output logic        m_udp_hdr_valid,
  input  logic        m_udp_hdr_ready,
  output logic [5:0]  m_udp_ip_dscp,
  output logic [1:0]  m_udp_ip_ecn,
  output logic [7:0]  m_udp_ip_ttl,
  output logic [31:0] m_udp_ip_dest_ip,
  output logic [15:0] m_udp_source_port,
  output logic [15:0] m_udp_dest_port,
  output logic [15:0] m_udp_length,
  output logic [15:0] m_udp_checksum,
  output logic [7:0]  m_udp_payload_axis_tdata,
  output logic        m_udp_payload_axis_tvalid,
  input  logic        m_udp_payload_axis_tready,
  output logic        m_udp_payload_axis_tlast,
  output logic        m_udp_payload_axis_tuser,
  output logic [15:0] frames_echoed,
  output logic [15:0] frames_dropped
);

  localparam logic [15:0] MAX_CNT = 16'(MAX_PAYLOAD);

  typedef enum logic [2:0] {IDLE, RX_STORE, RX_DROP, TX_HDR, TX_PAYLOAD} state_t;

  state_t      r_state, w_next;
  logic [7:0]  r_mem [0:(1<<ADDR_WIDTH)-1];
  logic [15:0] r_count, r_rd_ptr, r_length;
  logic        r_overflow;
  logic [31:0] r_src_ip;
  logic [15:0] r_src_port;
  logic [7:0]  r_tdata;
  logic        r_tvalid, r_tlast;
  logic [15:0] r_echoed, r_dropped;

  logic w_hdr_fire, w_rx_fire, w_txh_fire, w_tx_fire, w_rx_room, w_rx_bad;

  // Handshakes derive from state, not from the ready outputs, to avoid a comb loop.
  assign w_hdr_fire = s_udp_hdr_valid && (r_state == IDLE);
  assign w_rx_fire  = s_udp_payload_axis_tvalid && ((r_state == RX_STORE) || (r_state == RX_DROP));
  assign w_txh_fire = m_udp_hdr_ready && (r_state == TX_HDR);
  assign w_tx_fire  = r_tvalid && m_udp_payload_axis_tready && (r_state == TX_PAYLOAD);
  assign w_rx_room  = r_count < MAX_CNT;
  assign w_rx_bad   = r_overflow || s_udp_payload_axis_tuser || !w_rx_room;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next                    = r_state;
    s_udp_hdr_ready           = 1'b0;
    s_udp_payload_axis_tready = 1'b0;
    m_udp_hdr_valid           = 1'b0;
    case (r_state)
      IDLE: begin
        s_udp_hdr_ready = !reset;
        if (w_hdr_fire) w_next = (s_udp_dest_port == LISTEN_PORT) ? RX_STORE : RX_DROP;
      end
      RX_STORE: begin
        s_udp_payload_axis_tready = !reset;
        if (w_rx_fire && s_udp_payload_axis_tlast) w_next = w_rx_bad ? IDLE : TX_HDR;
      end
      RX_DROP: begin
        s_udp_payload_axis_tready = !reset;
        if (w_rx_fire && s_udp_payload_axis_tlast) w_next = IDLE;
      end
      TX_HDR: begin
        m_udp_hdr_valid = !reset;
        if (w_txh_fire) w_next = TX_PAYLOAD;
      end
      TX_PAYLOAD: begin
        if (w_tx_fire && r_tlast) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if ((r_state == RX_STORE) && w_rx_fire && w_rx_room)
      r_mem[r_count[ADDR_WIDTH-1:0]] <= s_udp_payload_axis_tdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_length   <= '0;
      r_overflow <= 1'b0;
      r_src_ip   <= '0;
      r_src_port <= '0;
      r_tdata    <= '0;
      r_tvalid   <= 1'b0;
      r_tlast    <= 1'b0;
      r_echoed   <= '0;
      r_dropped  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_hdr_fire) begin
            r_src_ip   <= s_udp_ip_source_ip;
            r_src_port <= s_udp_source_port;
            r_count    <= '0;
            r_overflow <= 1'b0;
          end
        end
        RX_STORE: begin
          if (w_rx_fire) begin
            if (w_rx_room) r_count <= r_count + 16'd1;
            else           r_overflow <= 1'b1;
            if (s_udp_payload_axis_tlast) begin
              if (w_rx_bad) r_dropped <= r_dropped + 16'd1;
              else          r_length  <= r_count + 16'd9;
            end
          end
        end
        RX_DROP: begin
          if (w_rx_fire && s_udp_payload_axis_tlast) r_dropped <= r_dropped + 16'd1;
        end
        TX_HDR: begin
          // Prefetch byte 0 so it is valid the cycle after the header handshake.
          if (w_txh_fire) begin
            r_tdata  <= r_mem[ADDR_WIDTH'(0)];
            r_tvalid <= 1'b1;
            r_tlast  <= (r_count == 16'd1);
            r_rd_ptr <= 16'd1;
          end
        end
        TX_PAYLOAD: begin
          if (w_tx_fire) begin
            if (r_tlast) begin
              r_tvalid <= 1'b0;
              r_tlast  <= 1'b0;
              r_echoed <= r_echoed + 16'd1;
            end else begin
              r_tdata  <= r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
              r_tlast  <= (r_rd_ptr == r_count - 16'd1);
              r_rd_ptr <= r_rd_ptr + 16'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign m_udp_ip_dscp             = 6'd0;
  assign m_udp_ip_ecn              = 2'd0;
  assign m_udp_ip_ttl              = REPLY_TTL;
  assign m_udp_ip_dest_ip          = r_src_ip;
  assign m_udp_source_port         = LISTEN_PORT;
  assign m_udp_dest_port           = r_src_port;
  assign m_udp_length              = r_length;
  assign m_udp_checksum            = 16'd0;
  assign m_udp_payload_axis_tdata  = r_tdata;
  assign m_udp_payload_axis_tvalid = r_tvalid;
  assign m_udp_payload_axis_tlast  = r_tlast;
  assign m_udp_payload_axis_tuser  = 1'b0;
  assign frames_echoed             = r_echoed;
  assign frames_dropped            = r_dropped;

endmodule

// File: tb/tb_udp_echo_responder.sv
// Directed bench for udp_echo_responder: echo, drop, error, size limits,
// transmit back-pressure and reset during transmit.
module tb_udp_echo_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_udp_hdr_valid, s_udp_hdr_ready;
  logic [31:0] s_udp_ip_source_ip;
  logic [15:0] s_udp_source_port, s_udp_dest_port;
  logic [7:0]  s_udp_payload_axis_tdata;
  logic        s_udp_payload_axis_tvalid, s_udp_payload_axis_tready;
  logic        s_udp_payload_axis_tlast, s_udp_payload_axis_tuser;
  logic        m_udp_hdr_valid, m_udp_hdr_ready;
  logic [5:0]  m_udp_ip_dscp;
  logic [1:0]  m_udp_ip_ecn;
  logic [7:0]  m_udp_ip_ttl;
  logic [31:0] m_udp_ip_dest_ip;
  logic [15:0] m_udp_source_port, m_udp_dest_port, m_udp_length, m_udp_checksum;
  logic [7:0]  m_udp_payload_axis_tdata;
  logic        m_udp_payload_axis_tvalid, m_udp_payload_axis_tready;
  logic        m_udp_payload_axis_tlast, m_udp_payload_axis_tuser;
  logic [15:0] frames_echoed, frames_dropped;

  int n_asserts = 0;
  int n_fail    = 0;
  logic [7:0] rx_buf [0:2047];

  always #5 clk = ~clk;

  udp_echo_responder dut (
    .clk(clk), .reset(reset),
    .s_udp_hdr_valid(s_udp_hdr_valid), .s_udp_hdr_ready(s_udp_hdr_ready),
    .s_udp_ip_source_ip(s_udp_ip_source_ip), .s_udp_source_port(s_udp_source_port),
    .s_udp_dest_port(s_udp_dest_port),
    .s_udp_payload_axis_tdata(s_udp_payload_axis_tdata),
    .s_udp_payload_axis_tvalid(s_udp_payload_axis_tvalid),
    .s_udp_payload_axis_tready(s_udp_payload_axis_tready),
    .s_udp_payload_axis_tlast(s_udp_payload_axis_tlast),
    .s_udp_payload_axis_tuser(s_udp_payload_axis_tuser),
    .m_udp_hdr_valid(m_udp_hdr_valid), .m_udp_hdr_ready(m_udp_hdr_ready),
    .m_udp_ip_dscp(m_udp_ip_dscp), .m_udp_ip_ecn(m_udp_ip_ecn), .m_udp_ip_ttl(m_udp_ip_ttl),
    .m_udp_ip_dest_ip(m_udp_ip_dest_ip), .m_udp_source_port(m_udp_source_port),
    .m_udp_dest_port(m_udp_dest_port), .m_udp_length(m_udp_length),
    .m_udp_checksum(m_udp_checksum),
    .m_udp_payload_axis_tdata(m_udp_payload_axis_tdata),
    .m_udp_payload_axis_tvalid(m_udp_payload_axis_tvalid),
    .m_udp_payload_axis_tready(m_udp_payload_axis_tready),
    .m_udp_payload_axis_tlast(m_udp_payload_axis_tlast),
    .m_udp_payload_axis_tuser(m_udp_payload_axis_tuser),
    .frames_echoed(frames_echoed), .frames_dropped(frames_dropped)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    s_udp_hdr_valid = 1'b0; s_udp_payload_axis_tvalid = 1'b0;
    s_udp_payload_axis_tlast = 1'b0; s_udp_payload_axis_tuser = 1'b0;
    m_udp_hdr_ready = 1'b0; m_udp_payload_axis_tready = 1'b0;
    tick(); tick();
    chk("rst_hdr_ready", s_udp_hdr_ready, 0);
    chk("rst_rx_tready", s_udp_payload_axis_tready, 0);
    chk("rst_tx_hdr_valid", m_udp_hdr_valid, 0);
    chk("rst_tx_tvalid", m_udp_payload_axis_tvalid, 0);
    chk("rst_tx_tlast_tuser", {m_udp_payload_axis_tlast, m_udp_payload_axis_tuser}, 0);
    chk("rst_dest_ip", m_udp_ip_dest_ip, 0);
    chk("rst_dest_port_len", {m_udp_dest_port, m_udp_length}, 0);
    chk("rst_counters", {frames_echoed, frames_dropped}, 0);
    reset = 1'b0;
    tick();
    chk("idle_hdr_ready", s_udp_hdr_ready, 1);
  endtask

  task automatic send_hdr(input logic [31:0] ip, input logic [15:0] sport, input logic [15:0] dport);
    int  n = 0;
    bit  done = 0;
    s_udp_hdr_valid = 1'b1;
    s_udp_ip_source_ip = ip; s_udp_source_port = sport; s_udp_dest_port = dport;
    while (!done && n < 100) begin
      done = s_udp_hdr_ready;
      tick();
      n++;
    end
    s_udp_hdr_valid = 1'b0;
    chk("rx_hdr_accept", 32'(done), 1);
  endtask

  task automatic send_payload(input int len, input bit err);
    int cycles = 0;
    int beats  = 0;
    for (int i = 0; i < len; i++) begin
      bit got = 0;
      int n   = 0;
      s_udp_payload_axis_tdata  = rx_buf[i];
      s_udp_payload_axis_tvalid = 1'b1;
      s_udp_payload_axis_tlast  = (i == len - 1);
      s_udp_payload_axis_tuser  = err && (i == len - 1);
      while (!got && n < 20) begin
        got = s_udp_payload_axis_tready;
        tick();
        n++;
        cycles++;
      end
      if (!got) break;
      beats++;
    end
    s_udp_payload_axis_tvalid = 1'b0;
    s_udp_payload_axis_tlast  = 1'b0;
    s_udp_payload_axis_tuser  = 1'b0;
    chk("rx_beats_accepted", beats, len);
    chk("rx_cycles", cycles, len);
  endtask

  task automatic recv_tx(input logic [31:0] ip, input logic [15:0] dport, input int len,
                         input int hdr_delay, input bit rand_ready);
    int n = 0;
    int idx = 0;
    bit stalled = 0;
    bit rdy;
    m_udp_hdr_ready = 1'b0;
    m_udp_payload_axis_tready = 1'b0;
    while (!m_udp_hdr_valid && n < 50) begin
      tick();
      n++;
    end
    chk("tx_hdr_valid", m_udp_hdr_valid, 1);
    chk("tx_dest_ip", m_udp_ip_dest_ip, ip);
    chk("tx_dest_port", m_udp_dest_port, dport);
    chk("tx_src_port", m_udp_source_port, 16'd5000);
    chk("tx_length", m_udp_length, 32'(len + 8));
    chk("tx_ttl", m_udp_ip_ttl, 8'd64);
    chk("tx_const", {m_udp_checksum, m_udp_ip_dscp, m_udp_ip_ecn}, 0);
    for (int d = 0; d < hdr_delay; d++) begin
      tick();
      chk("tx_hdr_hold_valid", m_udp_hdr_valid, 1);
      chk("tx_hdr_hold_len", m_udp_length, 32'(len + 8));
      chk("tx_hdr_hold_dst", {m_udp_dest_port, m_udp_ip_dest_ip[15:0]}, {dport, ip[15:0]});
      chk("tx_hdr_rx_blocked", {s_udp_hdr_ready, s_udp_payload_axis_tready}, 0);
    end
    m_udp_hdr_ready = 1'b1;
    tick();
    m_udp_hdr_ready = 1'b0;
    chk("tx_first_byte_latency", m_udp_payload_axis_tvalid, 1);
    n = 0;
    while (idx < len && n < len * 4 + 50) begin
      if (stalled || !rand_ready) chk("tx_tvalid_held", m_udp_payload_axis_tvalid, 1);
      if (m_udp_payload_axis_tvalid) begin
        chk("tx_tdata", m_udp_payload_axis_tdata, rx_buf[idx]);
        chk("tx_tlast", m_udp_payload_axis_tlast, 32'(idx == len - 1));
        chk("tx_tuser", m_udp_payload_axis_tuser, 0);
      end
      chk("tx_rx_blocked", {s_udp_hdr_ready, s_udp_payload_axis_tready}, 0);
      rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      m_udp_payload_axis_tready = rdy;
      stalled = m_udp_payload_axis_tvalid && !rdy;
      if (m_udp_payload_axis_tvalid && rdy) idx++;
      tick();
      n++;
    end
    m_udp_payload_axis_tready = 1'b0;
    chk("tx_byte_count", idx, len);
    chk("tx_done_tvalid", m_udp_payload_axis_tvalid, 0);
  endtask

  initial begin
    bit seen;
    reset = 1'b1;
    s_udp_hdr_valid = 1'b0; s_udp_ip_source_ip = '0; s_udp_source_port = '0; s_udp_dest_port = '0;
    s_udp_payload_axis_tdata = '0; s_udp_payload_axis_tvalid = 1'b0;
    s_udp_payload_axis_tlast = 1'b0; s_udp_payload_axis_tuser = 1'b0;
    m_udp_hdr_ready = 1'b0; m_udp_payload_axis_tready = 1'b0;

    // 1: basic 16-byte echo
    do_reset();
    for (int i = 0; i < 16; i++) rx_buf[i] = 8'(i + 1);
    send_hdr(32'hC0A8010A, 16'd1234, 16'd5000);
    send_payload(16, 0);
    recv_tx(32'hC0A8010A, 16'd1234, 16, 0, 0);
    chk("t1_echoed", frames_echoed, 1);
    chk("t1_dropped", frames_dropped, 0);

    // 2: other port is drained
    do_reset();
    for (int i = 0; i < 10; i++) rx_buf[i] = 8'(8'h50 + i);
    send_hdr(32'h0A000001, 16'd4321, 16'd80);
    send_payload(10, 0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      seen |= m_udp_hdr_valid;
      tick();
    end
    chk("t2_no_tx_hdr", 32'(seen), 0);
    chk("t2_dropped", frames_dropped, 1);
    chk("t2_echoed", frames_echoed, 0);

    // 3: errored frame dropped, then 1-byte echo
    do_reset();
    for (int i = 0; i < 4; i++) rx_buf[i] = 8'(8'hE0 + i);
    send_hdr(32'h0A000002, 16'd7, 16'd5000);
    send_payload(4, 1);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      seen |= m_udp_hdr_valid;
      tick();
    end
    chk("t3_no_tx_hdr", 32'(seen), 0);
    chk("t3_dropped", frames_dropped, 1);
    rx_buf[0] = 8'hAB;
    send_hdr(32'h0A000003, 16'd9, 16'd5000);
    send_payload(1, 0);
    recv_tx(32'h0A000003, 16'd9, 1, 0, 0);
    chk("t3_echoed", frames_echoed, 1);

    // 4: size limits
    do_reset();
    for (int i = 0; i < 1473; i++) rx_buf[i] = 8'(i * 7 + 3);
    send_hdr(32'h0A000004, 16'd11, 16'd5000);
    send_payload(1473, 0);
    tick();
    chk("t4_oversize_no_hdr", m_udp_hdr_valid, 0);
    chk("t4_oversize_dropped", frames_dropped, 1);
    for (int i = 0; i < 1472; i++) rx_buf[i] = 8'(i * 5 + 1);
    send_hdr(32'h0A000005, 16'd12, 16'd5000);
    send_payload(1472, 0);
    recv_tx(32'h0A000005, 16'd12, 1472, 0, 0);
    chk("t4_max_echoed", frames_echoed, 1);
    chk("t4_max_dropped", frames_dropped, 1);

    // 5: transmit back-pressure
    do_reset();
    for (int i = 0; i < 8; i++) rx_buf[i] = 8'(8'hA0 ^ (i * 17));
    send_hdr(32'hC0A80164, 16'd5555, 16'd5000);
    send_payload(8, 0);
    recv_tx(32'hC0A80164, 16'd5555, 8, 5, 1);
    chk("t5_echoed", frames_echoed, 1);

    // 6: reset during transmit
    do_reset();
    for (int i = 0; i < 16; i++) rx_buf[i] = 8'(8'h30 + i);
    send_hdr(32'h0A0000AA, 16'd100, 16'd5000);
    send_payload(16, 0);
    chk("t6_hdr_valid", m_udp_hdr_valid, 1);
    m_udp_hdr_ready = 1'b1;
    tick();
    m_udp_hdr_ready = 1'b0;
    m_udp_payload_axis_tready = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    chk("t6_byte3", m_udp_payload_axis_tdata, 8'h33);
    reset = 1'b1;
    m_udp_payload_axis_tready = 1'b0;
    tick();
    chk("t6_tvalid_cleared", m_udp_payload_axis_tvalid, 0);
    chk("t6_hdr_valid_cleared", m_udp_hdr_valid, 0);
    chk("t6_readies_cleared", {s_udp_hdr_ready, s_udp_payload_axis_tready}, 0);
    chk("t6_len_cleared", m_udp_length, 0);
    chk("t6_counters_cleared", {frames_echoed, frames_dropped}, 0);
    reset = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) rx_buf[i] = 8'(8'hC0 + i);
    send_hdr(32'h0A0000BB, 16'd200, 16'd5000);
    send_payload(8, 0);
    recv_tx(32'h0A0000BB, 16'd200, 8, 0, 0);
    chk("t6_echoed", frames_echoed, 1);
    chk("t6_dropped", frames_dropped, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/udp_echo_responder.md
Name: udp_echo_responder

Overview:
Responder at the UDP application end of the stack. It consumes received UDP frames (header plus 8-bit payload stream) from the UDP stack's receive output. Frames addressed to LISTEN_PORT are buffered in full, then sent back to the sender through the UDP stack's transmit input. All other frames are drained and discarded. It is the first application-level endpoint on the UDP stack and is used for loopback bring-up and latency measurement.

Parameters:
LISTEN_PORT, 16'd5000, UDP destination port that is echoed.
MAX_PAYLOAD, 1472, maximum payload bytes buffered; longer frames are dropped.
ADDR_WIDTH, 11, payload RAM address width; 2**ADDR_WIDTH >= MAX_PAYLOAD.
REPLY_TTL, 8'd64, IP TTL of reply frames.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
s_udp_hdr_valid  in  1  rx header valid
s_udp_hdr_ready  out  1  rx header ready
s_udp_ip_source_ip  in  32  sender IP
s_udp_source_port  in  16  sender port
s_udp_dest_port  in  16  destination port
s_udp_payload_axis_tdata  in  8  rx payload byte
s_udp_payload_axis_tvalid  in  1  rx payload valid
s_udp_payload_axis_tready  out  1  rx payload ready
s_udp_payload_axis_tlast  in  1  last rx byte
s_udp_payload_axis_tuser  in  1  rx frame error, qualified with tlast
m_udp_hdr_valid  out  1  tx header valid
m_udp_hdr_ready  in  1  tx header ready
m_udp_ip_dscp  out  6  constant 0
m_udp_ip_ecn  out  2  constant 0
m_udp_ip_ttl  out  8  REPLY_TTL
m_udp_ip_dest_ip  out  32  reply destination IP
m_udp_source_port  out  16  LISTEN_PORT
m_udp_dest_port  out  16  reply destination port
m_udp_length  out  16  8 + payload byte count
m_udp_checksum  out  16  constant 0 (checksum disabled)
m_udp_payload_axis_tdata  out  8  tx payload byte
m_udp_payload_axis_tvalid  out  1  tx payload valid
m_udp_payload_axis_tready  in  1  tx payload ready
m_udp_payload_axis_tlast  out  1  last tx byte
m_udp_payload_axis_tuser  out  1  constant 0
frames_echoed  out  16  count of frames echoed; wraps
frames_dropped  out  16  count of frames dropped; wraps

Behaviour:
- Single clock domain. Synchronous active-high reset. Reset returns the FSM to IDLE and clears byte count, read pointer and both counters.
- Reset values of outputs: every ready, valid, tlast and tuser output is 0; m_udp_ip_dest_ip, m_udp_dest_port and m_udp_length are 0. The RAM is not cleared.
- FSM states: IDLE, RX_STORE, RX_DROP, TX_HDR, TX_PAYLOAD.
- IDLE:
  - s_udp_hdr_ready=1.
  - On header handshake, latch the source IP and source port, then clear the byte count.
  - If dest_port==LISTEN_PORT, go to RX_STORE; otherwise go to RX_DROP.
- RX_STORE:
  - s_udp_payload_axis_tready=1.
  - Each accepted beat writes RAM[count] and increments count.
  - A beat arriving when count==MAX_PAYLOAD is not written and marks the frame overflowed.
  - On the tlast beat:
    - If overflowed, or tuser=1, or the tlast beat itself would overflow: increment frames_dropped and go to IDLE.
    - Otherwise go to TX_HDR.
- RX_DROP:
  - tready=1; beats are discarded.
  - On the tlast beat, increment frames_dropped and go to IDLE.
- TX_HDR:
  - m_udp_hdr_valid=1 with dest_ip = latched source IP, dest_port = latched source port, length = count+8 (16-bit).
  - Header fields stay stable until handshake. On handshake, go to TX_PAYLOAD.
- TX_PAYLOAD:
  - Streams RAM[0..count-1] in order. The RAM read has 1-cycle latency and feeds a registered output stage, so the first byte appears 1 cycle after the header handshake.
  - While tready=0, tdata, tvalid and tlast hold stable and no byte is skipped or repeated.
  - tlast=1 only on byte count-1.
  - On the last handshake, increment frames_echoed and go to IDLE.
- Back-pressure:
  - s_udp_hdr_ready=0 and s_udp_payload_axis_tready=0 in TX_HDR and TX_PAYLOAD; no rx frame is accepted during transmit.
  - s_udp_hdr_ready=0 in RX_STORE and RX_DROP.
- Byte count comes from the stream, not from a header length field. A minimum frame is 1 byte; a tlast on the first beat gives count=1.
- Throughput: 1 byte/cycle in both directions when the peer is always ready.
- Reset mid-frame abandons the frame: outputs return to reset values in the next cycle and neither counter increments.

Test Plan:
1. Header {ip=192.168.1.10, sport=1234, dport=5000}, payload 0x01..0x10 (16 bytes) -> tx header {dest_ip=192.168.1.10, dport=1234, sport=5000, length=24, ttl=64, checksum=0}, payload 0x01..0x10, tlast on 0x10, frames_echoed=1.
2. dport=80, 10 bytes -> all beats accepted, no tx header, frames_dropped=1.
3. dport=5000, 4 bytes, tuser=1 on tlast -> no tx, frames_dropped=1. Then a valid 1-byte frame 0xAB -> length=9, single beat 0xAB with tlast.
4. dport=5000 with MAX_PAYLOAD+1 bytes -> dropped, frames_dropped=1. Exactly MAX_PAYLOAD bytes -> echoed with length=MAX_PAYLOAD+8.
5. Echo of 8 bytes with m_udp_payload_axis_tready toggled pseudo-randomly and m_udp_hdr_ready delayed 5 cycles -> byte order intact, data stable while stalled, rx tready=0 throughout.
6. reset asserted at byte 3 of a 16-byte tx -> next cycle all valids are 0; a following echo frame completes correctly; frames_echoed counts only that frame.
